// File: rtl/mdu_unit.sv
// Multiply/divide unit holding the HI/LO pair.
// Fixed-latency mult/div with direct mthi/mtlo writes.
module mdu_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             is_signed;
    logic             sa;
    logic             sb;
    logic [2*WIDTH-1:0] ma;
    logic [2*WIDTH-1:0] mb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] ua;
    logic [WIDTH-1:0] ub;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Sign-magnitude division; the MIN / -1 case falls out as MIN, 0.
    always_comb begin
        is_signed = ~op_q[0];
        sa        = is_signed & a_q[WIDTH-1];
        sb        = is_signed & b_q[WIDTH-1];
        ma        = {{WIDTH{sa}}, a_q};
        mb        = {{WIDTH{sb}}, b_q};
        prod      = ma * mb;
        ua        = sa ? -a_q : a_q;
        ub        = sb ? -b_q : b_q;
        q_mag     = '0;
        r_mag     = '0;
        if (ub != '0) begin
            q_mag = ua / ub;
            r_mag = ua % ub;
        end
        quo = (sa ^ sb) ? -q_mag : q_mag;
        rem = sa ? -r_mag : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        start & ~op[2]: begin
                            op_q  <= op[1:0];
                            a_q   <= a;
                            b_q   <= b;
                            cnt   <= op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                        start & (op == 3'b100): hi <= a;
                        start & (op == 3'b101): lo <= a;
                        default: ;
                    endcase
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (!op_q[1]) begin
                            {hi, lo} <= prod;
                        end else if (b_q != '0) begin
                            lo <= quo;
                            hi <= rem;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomised scoreboard bench for mdu_unit.
// A plain-arithmetic HI/LO model feeds an expected-result queue.
module tb_mdu_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        s_start = 1'b0;
    logic [2:0]  s_op = '0;
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic        s_busy;
    logic        s_done;
    logic [15:0] s_hi;
    logic [15:0] s_lo;

    exp_t        sbq[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          errors = 0;
    int          checks = 0;
    int          bcnt = 0;

    always #5 clk = ~clk;

    mdu_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mdu_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(2)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op),
        .a(s_a), .b(s_b), .busy(s_busy), .done(s_done),
        .hi(s_hi), .lo(s_lo)
    );

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endfunction

    // Architectural HI/LO after a mult/div, from the arithmetic rules.
    function automatic void model(input logic [2:0] o,
                                  input logic [31:0] x, input logic [31:0] y);
        longint      ps;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] pu;
        int          sx;
        int          sy;
        sx = x;
        sy = y;
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin
                ps = longint'(sx) * longint'(sy);
                {m_hi, m_lo} = ps;
            end
            3'd1: begin
                pu = ux * uy;
                {m_hi, m_lo} = pu;
            end
            3'd2: if (y != 0) begin
                if (x == 32'h8000_0000 && sy == -1) begin
                    m_lo = x;
                    m_hi = 0;
                end else begin
                    m_lo = sx / sy;
                    m_hi = sx % sy;
                end
            end
            3'd3: if (y != 0) begin
                m_lo = x / y;
                m_hi = x % y;
            end
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("md_hi", 64'(hi), 64'(e.hi));
                chk("md_lo", 64'(lo), 64'(e.lo));
                chk("md_busy_cycles", 64'(bcnt), 64'(e.lat));
            end
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
        end else begin
            bcnt = 0;
        end
    end

    // Called at a negedge with the unit idle; returns at a negedge, idle.
    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        int n;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (o < 3'd4) begin
            model(o, x, y);
            sbq.push_back('{m_hi, m_lo, (o[1] ? 10 : 5)});
        end
        @(negedge clk);
        start = 1'b0;
        if (o < 3'd4) begin
            n = 0;
            while (busy && n < 40) begin
                start = 1'($urandom);
                op    = 3'($urandom);
                a     = $urandom;
                b     = $urandom;
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            if (n >= 40) chk("busy_timeout", 64'd1, 64'd0);
        end else if (o == 3'd4) begin
            m_hi = x;
            chk("mthi", {30'b0, busy, done, hi}, {32'b0, x});
        end else if (o == 3'd5) begin
            m_lo = x;
            chk("mtlo", {30'b0, busy, done, lo}, {32'b0, x});
        end else begin
            chk("reserved_op", {hi, lo}, {m_hi, m_lo});
            chk("reserved_busy", 64'(busy), 64'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 7)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_state", {30'b0, busy, done, hi}, 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        issue(3'd0, 32'hFFFF_FFFF, 32'h2);
        issue(3'd1, 32'hFFFF_FFFF, 32'h2);
        issue(3'd2, 32'hFFFF_FFF9, 32'h2);
        issue(3'd3, 32'h7, 32'h2);
        issue(3'd4, 32'h12, 32'h0);
        issue(3'd5, 32'h34, 32'h0);
        issue(3'd2, 32'h1234_5678, 32'h0);
        chk("div0_keeps_hilo", {hi, lo}, {32'h12, 32'h34});
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'hDEAD_BEEF, 32'h1);
        issue(3'd7, 32'hCAFE_F00D, 32'h1);

        // Abort a mult with reset in its third busy cycle.
        start = 1'b1; op = 3'd0; a = 32'h3; b = 32'h5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
        chk("reset_abort", {30'b0, busy, done, hi}, 64'd0);
        chk("reset_abort_lo", 64'(lo), 64'd0);
        repeat (8) @(negedge clk);

        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'h55;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("reset_beats_start", 64'(hi), 64'd0);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom), pick(), pick());
            if ($urandom % 3 == 0) @(negedge clk);
        end

        s_start = 1'b1; s_op = 3'd0; s_a = 16'h8000; s_b = 16'h8000;
        @(negedge clk);
        s_start = 1'b0;
        chk("w16_mult_busy", {62'b0, s_busy, s_done}, 64'b10);
        @(negedge clk);
        chk("w16_mult_done", {30'b0, s_busy, s_done, s_hi, s_lo},
            {30'b0, 2'b01, 16'h4000, 16'h0000});
        s_start = 1'b1; s_op = 3'd2; s_a = 16'h8000; s_b = 16'hFFFF;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("w16_div_ovf", {30'b0, s_busy, s_done, s_hi, s_lo},
            {30'b0, 2'b01, 16'h0000, 16'h8000});

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
